// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: control, instruction-memory and issue signals of the fetch sequencer
interface pc_fetch_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
);
  logic               start;
  logic               jump_en;
  logic [PC_W-1:0]    jump_target;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;
  logic               halted;
  logic               misalign_err;
  modport master (
    output start, jump_en, jump_target, imem_ready, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, pc, halted, misalign_err
  );
  modport slave (
    input  start, jump_en, jump_target, imem_ready, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, pc, halted, misalign_err
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: program counter and fetch/issue sequencer that halts at the exit address
module pc_fetch_sequencer #(
  parameter int              PC_W      = 8,
  parameter int              INSTR_W   = 32,
  parameter int              PC_STEP   = 4,
  parameter logic [PC_W-1:0] RESET_PC  = 8'h04,
  parameter logic [PC_W-1:0] EXIT_ADDR = 8'h80
) (
  input logic                clk,
  input logic                rst,
  pc_fetch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
  state_t             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_imem_req;
  logic               r_instr_valid;
  logic               r_halted;
  logic               r_misalign;
  logic [PC_W-1:0]    w_next_pc;
  logic               w_misalign;
  logic               w_exit;
  assign w_next_pc  = bus.jump_en ? bus.jump_target : r_pc + PC_W'(PC_STEP);
  assign w_misalign = bus.jump_en && |(bus.jump_target & PC_W'(PC_STEP - 1));
  assign w_exit     = w_next_pc == EXIT_ADDR;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: if (bus.imem_ready) begin
          r_instr       <= bus.imem_rdata;
          r_state       <= ISSUE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b1;
        end
        ISSUE: if (bus.instr_ready) begin
          r_instr_valid <= 1'b0;
          if (w_misalign) begin
            r_misalign <= 1'b1;
            r_halted   <= 1'b1;
            r_state    <= HALT;
          end else begin
            r_pc       <= w_next_pc;
            r_halted   <= w_exit;
            r_imem_req <= !w_exit;
            r_state    <= w_exit ? HALT : FETCH;
          end
        end
        default: ;
      endcase
    end
  end
  assign bus.imem_req     = r_imem_req;
  assign bus.imem_addr    = r_pc;
  assign bus.pc           = r_pc;
  assign bus.instr_valid  = r_instr_valid;
  assign bus.instr        = r_instr;
  assign bus.halted       = r_halted;
  assign bus.misalign_err = r_misalign;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: randomized scenarios checked against a transaction-level PC model
module tb_pc_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] garbage = 32'h0;
  int n_cmp = 0;
  int n_bad = 0;
  int m_phase;
  int m_pc;
  bit m_err;
  logic [31:0] m_instr;
  always #5 clk = ~clk;
  pc_fetch_sequencer_if #(.PC_W(8), .INSTR_W(32)) bus ();
  pc_fetch_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3 ^ {a[3:0], a[7:4]}};
  endfunction
  assign bus.imem_rdata = bus.imem_ready ? mem_word(bus.imem_addr) : garbage;
  function automatic logic [51:0] exp_vec();
    return {8'(m_pc), 8'(m_pc), m_phase == 1, m_phase == 2, m_phase == 3, m_err, m_instr};
  endfunction
  function automatic logic [51:0] dut_vec();
    return {bus.pc, bus.imem_addr, bus.imem_req, bus.instr_valid, bus.halted, bus.misalign_err, bus.instr};
  endfunction
  task automatic tick(input bit st, input bit je, input int tgt, input bit ir, input bit rdy);
    bus.start = st;
    bus.jump_en = je;
    bus.jump_target = tgt[7:0];
    bus.imem_ready = ir;
    bus.instr_ready = rdy;
    garbage = $urandom;
    case (m_phase)
      0: if (st) m_phase = 1;
      1: if (ir) begin m_instr = mem_word(8'(m_pc)); m_phase = 2; end
      2: if (rdy) begin
        if (je && (tgt % 4) != 0) begin m_err = 1; m_phase = 3; end
        else begin
          m_pc = je ? tgt % 256 : (m_pc + 4) % 256;
          m_phase = (m_pc == 128) ? 3 : 1;
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'($urandom);
    bus.jump_en = 1'($urandom);
    bus.jump_target = 8'($urandom);
    bus.imem_ready = 1'($urandom);
    bus.instr_ready = 1'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_phase = 0;
    m_pc = 4;
    m_err = 0;
    m_instr = '0;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_vec() !== 52'h04_04_0_00000000) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), 52'h04_04_0_00000000);
    end
    tick(0, 1, 8'h40, 1, 1);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL idle_hold: got %h want %h", dut_vec(), exp_vec()); end
  endtask
  task automatic test_sequential();
    tick(1, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL seq_cycle%0d: got %h want %h", i, dut_vec(), exp_vec()); end
      tick(0, 0, 0, 1, 1);
    end
    n_cmp++;
    if (bus.imem_addr !== 8'h10 || bus.imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL seq_addr: got addr %h req %b want addr 10 req 1", bus.imem_addr, bus.imem_req);
    end
  endtask
  task automatic test_jump();
    int tgts[3] = '{8'h38, 8'h50, 8'h10};
    foreach (tgts[k]) begin
      tick(0, 1, 8'h24, 1, 1);
      n_cmp++;
      if (bus.instr !== mem_word(bus.pc) || dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL jump_issue%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      tick(0, 1, tgts[k], 1, 1);
      n_cmp++;
      if (bus.imem_addr !== 8'(tgts[k]) || dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL jump_target%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_exit();
    tick(0, 0, 0, 1, 1);
    tick(0, 1, 8'h7C, 1, 1);
    tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.pc !== 8'h80 || bus.halted !== 1'b1 || dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL exit_seq%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      tick(1, 1, 8'h20, 1, 1);
    end
    do_reset();
    tick(1, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    tick(0, 1, 8'h80, 1, 1);
    n_cmp++;
    if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL exit_jump: got %h want %h", dut_vec(), exp_vec());
    end
  endtask
  task automatic test_stall();
    do_reset();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, $urandom_range(0, 255), 0, 1);
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h04 || dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL stall_fetch%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, $urandom_range(0, 255), 1, 0);
      n_cmp++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== mem_word(8'h04) || dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL stall_issue%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    tick(0, 0, 0, 1, 1);
    n_cmp++;
    if (bus.pc !== 8'h08 || dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL stall_release: got %h want %h", dut_vec(), exp_vec());
    end
  endtask
  task automatic test_misalign();
    do_reset();
    tick(1, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    tick(0, 1, 8'h13, 1, 1);
    n_cmp++;
    if (bus.misalign_err !== 1'b1 || bus.halted !== 1'b1 || bus.pc !== 8'h04 || dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL misalign: got %h want %h", dut_vec(), exp_vec());
    end
    tick(1, 0, 0, 1, 1);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL misalign_hold: got %h want %h", dut_vec(), exp_vec()); end
  endtask
  task automatic test_wrap();
    do_reset();
    tick(1, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    tick(0, 1, 8'hFC, 1, 1);
    tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    n_cmp++;
    if (bus.imem_addr !== 8'h00 || bus.misalign_err !== 1'b0 || bus.imem_req !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL wrap: got %h want %h", dut_vec(), exp_vec());
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    do_reset();
    n_cmp++;
    if (dut_vec() !== 52'h04_04_0_00000000) begin n_bad++; $display("FAIL reset_fetch: got %h", dut_vec()); end
    tick(1, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    tick(0, 1, 8'h22, 1, 1);
    do_reset();
    n_cmp++;
    if (dut_vec() !== 52'h04_04_0_00000000) begin n_bad++; $display("FAIL reset_halt: got %h", dut_vec()); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_phase == 3 && $urandom_range(0, 3) == 0) do_reset();
      else tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 63) * 4,
                1'($urandom), 1'($urandom));
      n_cmp++;
      if (dut_vec() !== exp_vec() || (bus.imem_req && bus.instr_valid)) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask
  initial begin
    bus.start = 0;
    bus.jump_en = 0;
    bus.jump_target = 0;
    bus.imem_ready = 0;
    bus.instr_ready = 0;
    test_reset();
    test_sequential();
    test_jump();
    test_exit();
    test_stall();
    test_misalign();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Program-counter register and fetch sequencer for the 8-bit-address core.
- Consumes the resolved jump target produced by the label-to-PC mapper. Drives instruction-memory fetches and hands fetched instructions downstream with a valid/ready handshake.
- Halts when the PC reaches the exit label address.

Parameters:
- PC_W, 8, PC/address width in bits.
- INSTR_W, 32, instruction word width.
- PC_STEP, 4, sequential PC increment.
- RESET_PC, 8'h04, PC value after reset (main label).
- EXIT_ADDR, 8'h80, PC value that forces HALT (exit label).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin fetching from the current PC; only honoured in IDLE.
- jump_en  in  1  take jump_target at the next PC update.
- jump_target  in  PC_W  resolved target from the label mapper.
- imem_req  out  PC_W-independent 1  fetch request to instruction memory.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  INSTR_W  fetched word.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  downstream accepts instr.
- instr  out  INSTR_W  captured instruction.
- pc  out  PC_W  current PC.
- halted  out  1  sequencer in HALT.
- misalign_err  out  1  sticky; a jump target was not a multiple of PC_STEP.

Behaviour:
- States: IDLE, FETCH, ISSUE, HALT.
- Reset (rst=1 at an edge), regardless of state or an in-flight fetch:
  - state←IDLE, pc←RESET_PC, instr←0.
  - instr_valid, imem_req, halted, misalign_err all ←0.
  - rst has priority over every other input.
- IDLE:
  - imem_req=0, instr_valid=0.
  - start=1 → FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Hold FETCH while imem_ready=0.
  - imem_ready=1 → instr←imem_rdata, state←ISSUE. instr_valid rises the following cycle, so fetch latency is 1 cycle after imem_ready.
- ISSUE:
  - instr_valid=1, imem_req=0; instr and pc stable until the handshake.
  - Handshake = instr_valid & instr_ready. On the handshake edge:
    - jump_en=1 and jump_target[1:0]≠0 → misalign_err←1, pc unchanged, state←HALT.
    - jump_en=1 and target aligned → next_pc=jump_target.
    - jump_en=0 → next_pc=pc+PC_STEP, modulo 2^PC_W (252+4=0; wrap is legal, not an error).
    - Then pc←next_pc. next_pc==EXIT_ADDR → HALT; otherwise → FETCH.
  - jump_en/jump_target are sampled only on the handshake edge; ignored at all other times.
  - instr_ready=0 → remain in ISSUE indefinitely (stall); no output changes.
- HALT:
  - halted=1, imem_req=0, instr_valid=0; pc holds its final value.
  - Leave HALT only via rst. start is ignored.
- start is ignored outside IDLE.
- Throughput: at most one instruction per 2 cycles (FETCH→ISSUE) with imem_ready and instr_ready tied high.
- Invariants: imem_req and instr_valid are never both 1. imem_addr always equals pc.

Test Plan:
- Reset then start, imem_ready=1, instr_ready=1, jump_en=0 → imem_addr sequence 0x04,0x08,0x0C; instr_valid pulses every other cycle; instr matches imem_rdata per address.
- Handshake with jump_en=1, jump_target=0x38 at pc=0x10 → next imem_addr=0x38. Repeat with target 0x50, then 0x10 → fetches follow the targets.
- Jump to 0x80, or sequential step from 0x7C → pc=0x80, halted=1 next cycle, imem_req stays 0; start pulses are ignored.
- imem_ready held 0 for 5 cycles, then instr_ready held 0 for 3 cycles → imem_req stays high for 5 cycles with stable addr; then instr_valid/instr stay stable 3 cycles; pc advances only after the handshake.
- jump_target=0x13 with jump_en=1 on handshake → misalign_err=1, halted=1, pc unchanged.
- Jump to 0xFC, then sequential step → fetch at 0x00 (wrap), no error.
- rst asserted mid-FETCH and again in HALT → next cycle state IDLE, pc=0x04, all outputs 0, misalign_err cleared.
